perceptron_eval: RTL and testbench
==================================

PERCEPTRON_EVAL -- requirements
Module: perceptron_eval

Interface
REQ-001 Parameter LIMIAR, default 1, signed firing threshold; prediction is 1 when the weighted sum is >= LIMIAR.
REQ-002 Parameter WW, default 8, width of each signed weight.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input, rst input.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 w_valid  input  1  weight pair offered.
REQ-007 w0_in, w1_in  input  WW each  signed trained weights.
REQ-008 w_ready  output  1  weight pair accepted when w_valid and w_ready are both high.
REQ-009 s_valid  input  1  sample offered.
REQ-010 s_x  input  2  sample features; bit0 = x0, bit1 = x1.
REQ-011 s_target  input  1  expected class.
REQ-012 s_ready  output  1  sample accepted when s_valid and s_ready are both high.
REQ-013 p_valid  output  1  result available.
REQ-014 p_y  output  1  predicted class.
REQ-015 p_err  output  2  signed error, target minus prediction, in {-1, 0, +1}.
REQ-016 p_ready  input  1  downstream accepts the result.
REQ-017 total, correct  output  8 each  evaluated-sample and correct-sample counters.
REQ-018 all_ok  output  1  high when total != 0 and correct == total.
REQ-019 loaded  output  1  high in state RUN.

Function
REQ-020 The FSM SHALL have two states: IDLE (no weights) and RUN; IDLE goes to RUN on a weight handshake; RUN never returns to IDLE except through rst.
REQ-021 w_ready SHALL equal !p_valid, in both states; a reload is accepted only when the output buffer is empty.
REQ-022 On a weight handshake, the block SHALL update the weight registers and clear total and correct in the same edge.
REQ-023 s_ready SHALL equal (state==RUN) & !w_valid & (!p_valid | p_ready); a pending weight offer blocks new samples.
REQ-024 Sum arithmetic: sign-extend each weight to WW+1 bits, gate it with its feature bit, and add at WW+1 bits with no overflow or truncation.
REQ-025 Prediction: p_y = (sum >= LIMIAR), using a signed comparison.
REQ-026 Error: p_err = {1'b0,s_target} - {1'b0,p_y}, computed as 2-bit signed.
REQ-027 Latency: the result SHALL be registered and appear with p_valid high on the edge after the sample handshake (1 cycle).
REQ-028 Output buffer: one entry; p_y, p_err and p_valid SHALL hold stable while p_valid=1 and p_ready=0.
REQ-029 Output buffer: on p_ready=1 with a new sample handshake in the same cycle, the buffer SHALL reload with no bubble.
REQ-030 Output buffer: on p_ready=1 with no new sample, p_valid SHALL fall.
REQ-031 Counters: total increments by 1 on each sample handshake; correct increments by 1 when the computed err is 0.
REQ-032 Counters: each counter SHALL saturate at 255 with no wrap.
REQ-033 Counters: a weight load takes priority over the counter increment (not simultaneous by REQ-023).
REQ-034 Weight registers and counters SHALL change only at handshakes; input changes without valid SHALL have no effect.

Reset
REQ-035 On rst: state=IDLE, w0=w1=0, total=correct=0, p_valid=0, p_y=0, p_err=0, all_ok=0, loaded=0, s_ready=0, w_ready=1.
REQ-036 rst asserted mid-operation SHALL discard any buffered result immediately, asynchronously, with no handshake completing.

Verification
REQ-037 Load w0=1, w1=1; stream x=00/0, 01/1, 10/1, 11/1 with p_ready=1 -> p_y=0,1,1,1 one cycle after each sample; p_err all 0; total=4, correct=4, all_ok=1.
REQ-038 Load w0=0, w1=0; send x=01, target 1 -> p_y=0, p_err=+1 (2'b01); total=1, correct=0, all_ok=0.
REQ-039 Load w0=-128, w1=127; send x=11, target 0 -> sum=-1, p_y=0, p_err=0; no overflow artefact.
REQ-040 Hold p_ready=0 with one result buffered -> s_ready=0 and w_ready=0; p_y and p_err stable for 5 cycles; raising p_ready with s_valid high gives a back-to-back transfer.
REQ-041 Send 300 correct samples -> total=255, correct=255, all_ok=1; then reload weights -> total=0, correct=0, all_ok=0.
REQ-042 Assert rst while p_valid=1 in RUN -> same cycle: p_valid=0, loaded=0, counters 0; samples refused until a new weight load.

Source files
------------

// File: rtl/perceptron_eval.sv
// Two-input perceptron evaluator: loads a trained weight pair, classifies streamed
// samples through a one-entry output buffer, and tracks saturating accuracy counters.
module perceptron_eval #(
    parameter int LIMIAR = 1,
    parameter int WW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_valid,
    input  logic [WW-1:0] w0_in,
    input  logic [WW-1:0] w1_in,
    output logic          w_ready,
    input  logic          s_valid,
    input  logic [1:0]    s_x,
    input  logic          s_target,
    output logic          s_ready,
    output logic          p_valid,
    output logic          p_y,
    output logic [1:0]    p_err,
    input  logic          p_ready,
    output logic [7:0]    total,
    output logic [7:0]    correct,
    output logic          all_ok,
    output logic          loaded
);

    // state | meaning
    // IDLE  | no weights loaded yet, samples refused
    // RUN   | weights loaded, samples evaluated
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;

    logic                 w_fire;
    logic                 s_fire;
    logic [WW:0]          term0;
    logic [WW:0]          term1;
    logic [WW:0]          sum;
    logic signed [31:0]   sum_ext;
    logic                 y_next;
    logic [1:0]           err_next;

    assign w_ready = !p_valid;
    assign s_ready = (state == RUN) && !w_valid && (!p_valid || p_ready);
    assign w_fire  = w_valid && w_ready;
    assign s_fire  = s_valid && s_ready;
    assign loaded  = (state == RUN);
    assign all_ok  = (total != 8'd0) && (correct == total);

    // One extra bit of headroom makes the two-term sum exact for any weights.
    assign term0    = s_x[0] ? {w0[WW-1], w0} : '0;
    assign term1    = s_x[1] ? {w1[WW-1], w1} : '0;
    assign sum      = term0 + term1;
    assign sum_ext  = {{(31-WW){sum[WW]}}, sum};
    assign y_next   = (sum_ext >= LIMIAR);
    assign err_next = {1'b0, s_target} - {1'b0, y_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            w0      <= '0;
            w1      <= '0;
            total   <= 8'd0;
            correct <= 8'd0;
            p_valid <= 1'b0;
            p_y     <= 1'b0;
            p_err   <= 2'b00;
        end else begin
            if (w_fire) begin
                state   <= RUN;
                w0      <= w0_in;
                w1      <= w1_in;
                total   <= 8'd0;
                correct <= 8'd0;
            end else if (s_fire) begin
                if (total != 8'hFF)
                    total <= total + 8'd1;
                if ((err_next == 2'b00) && (correct != 8'hFF))
                    correct <= correct + 8'd1;
            end

            if (s_fire) begin
                p_valid <= 1'b1;
                p_y     <= y_next;
                p_err   <= err_next;
            end else if (p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_eval.sv
// Directed bench for perceptron_eval with hand-computed expectations (LIMIAR=1, WW=8).
module tb_perceptron_eval;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_valid = 1'b0;
    logic [7:0] w0_in = 8'd0;
    logic [7:0] w1_in = 8'd0;
    logic       w_ready;
    logic       s_valid = 1'b0;
    logic [1:0] s_x = 2'b00;
    logic       s_target = 1'b0;
    logic       s_ready;
    logic       p_valid;
    logic       p_y;
    logic [1:0] p_err;
    logic       p_ready = 1'b1;
    logic [7:0] total;
    logic [7:0] correct;
    logic       all_ok;
    logic       loaded;

    int checks = 0;
    int errors = 0;

    perceptron_eval #(.LIMIAR(1), .WW(8)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w0_in(w0_in), .w1_in(w1_in), .w_ready(w_ready),
        .s_valid(s_valid), .s_x(s_x), .s_target(s_target), .s_ready(s_ready),
        .p_valid(p_valid), .p_y(p_y), .p_err(p_err), .p_ready(p_ready),
        .total(total), .correct(correct), .all_ok(all_ok), .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        int n;
        w_valid = 1'b1; w0_in = a; w1_in = b; n = 0;
        while (!w_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (w_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_timeout w_ready=%0b required 1", w_ready);
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] x, input logic t);
        s_valid = 1'b1; s_x = x; s_target = t;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({p_valid, p_y, p_err, all_ok, loaded, s_ready, w_ready} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_flags got=%b required 00000001",
                     {p_valid, p_y, p_err, all_ok, loaded, s_ready, w_ready});
        end
        checks++;
        if ({total, correct} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_counters total=%0d correct=%0d required 0 0", total, correct);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b0 || p_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_refuses s_ready=%0b p_valid=%0b required 0 0", s_ready, p_valid);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_or_gate;
        logic [1:0] xs [4];
        logic       ys [4];
        xs = '{2'b00, 2'b01, 2'b10, 2'b11};
        ys = '{1'b0, 1'b1, 1'b1, 1'b1};
        p_ready = 1'b1;
        load(8'd1, 8'd1);
        checks++;
        if (loaded !== 1'b1) begin
            errors++;
            $display("FAIL or_loaded got=%0b required 1", loaded);
        end
        for (int i = 0; i < 4; i++) begin
            send(xs[i], ys[i]);
            checks++;
            if (p_valid !== 1'b1 || p_y !== ys[i] || p_err !== 2'b00) begin
                errors++;
                $display("FAIL or_sample%0d valid=%0b y=%0b err=%b required 1 %0b 00",
                         i, p_valid, p_y, p_err, ys[i]);
            end
        end
        checks++;
        if (total !== 8'd4 || correct !== 8'd4 || all_ok !== 1'b1) begin
            errors++;
            $display("FAIL or_counters total=%0d correct=%0d all_ok=%0b required 4 4 1",
                     total, correct, all_ok);
        end
        @(posedge clk); #1;
        checks++;
        if (p_valid !== 1'b0) begin
            errors++;
            $display("FAIL or_drain p_valid=%0b required 0", p_valid);
        end
    endtask

    task automatic test_zero_weights;
        p_ready = 1'b1;
        load(8'd0, 8'd0);
        checks++;
        if (total !== 8'd0 || correct !== 8'd0 || all_ok !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear total=%0d correct=%0d all_ok=%0b required 0 0 0",
                     total, correct, all_ok);
        end
        send(2'b01, 1'b1);
        checks++;
        if (p_y !== 1'b0 || p_err !== 2'b01) begin
            errors++;
            $display("FAIL zero_pred y=%0b err=%b required 0 01", p_y, p_err);
        end
        checks++;
        if (total !== 8'd1 || correct !== 8'd0 || all_ok !== 1'b0) begin
            errors++;
            $display("FAIL zero_counters total=%0d correct=%0d all_ok=%0b required 1 0 0",
                     total, correct, all_ok);
        end
    endtask

    task automatic test_extremes;
        p_ready = 1'b1;
        load(8'h80, 8'h7F);
        send(2'b11, 1'b0);
        checks++;
        if (p_y !== 1'b0 || p_err !== 2'b00) begin
            errors++;
            $display("FAIL ext_minus1 y=%0b err=%b required 0 00", p_y, p_err);
        end
        send(2'b10, 1'b1);
        checks++;
        if (p_y !== 1'b1 || p_err !== 2'b00) begin
            errors++;
            $display("FAIL ext_127 y=%0b err=%b required 1 00", p_y, p_err);
        end
        send(2'b01, 1'b0);
        checks++;
        if (p_y !== 1'b0 || p_err !== 2'b00) begin
            errors++;
            $display("FAIL ext_m128 y=%0b err=%b required 0 00", p_y, p_err);
        end
        load(8'h7F, 8'h7F);
        send(2'b11, 1'b1);
        checks++;
        if (p_y !== 1'b1 || p_err !== 2'b00) begin
            errors++;
            $display("FAIL ext_254 y=%0b err=%b required 1 00", p_y, p_err);
        end
        send(2'b11, 1'b0);
        checks++;
        if (p_y !== 1'b1 || p_err !== 2'b11) begin
            errors++;
            $display("FAIL ext_neg_err y=%0b err=%b required 1 11", p_y, p_err);
        end
        checks++;
        if (total !== 8'd2 || correct !== 8'd1) begin
            errors++;
            $display("FAIL ext_counters total=%0d correct=%0d required 2 1", total, correct);
        end
    endtask

    task automatic test_back_to_back;
        p_ready = 1'b1;
        load(8'd1, 8'd1);
        p_ready = 1'b0;
        send(2'b01, 1'b1);
        s_valid = 1'b1; s_x = 2'b00; s_target = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_ready !== 1'b0 || w_ready !== 1'b0 || p_valid !== 1'b1 ||
                p_y !== 1'b1 || p_err !== 2'b00) begin
                errors++;
                $display("FAIL stall_cycle%0d s_rdy=%0b w_rdy=%0b valid=%0b y=%0b err=%b required 0 0 1 1 00",
                         i, s_ready, w_ready, p_valid, p_y, p_err);
            end
        end
        p_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_s_ready got=%0b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        checks++;
        if (p_valid !== 1'b1 || p_y !== 1'b0 || p_err !== 2'b01) begin
            errors++;
            $display("FAIL b2b_reload valid=%0b y=%0b err=%b required 1 0 01", p_valid, p_y, p_err);
        end
        checks++;
        if (total !== 8'd2 || correct !== 8'd1) begin
            errors++;
            $display("FAIL b2b_counters total=%0d correct=%0d required 2 1", total, correct);
        end
        @(posedge clk); #1;
        checks++;
        if (p_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain p_valid=%0b required 0", p_valid);
        end
    endtask

    task automatic test_saturation;
        p_ready = 1'b1;
        load(8'd1, 8'd1);
        s_valid = 1'b1; s_x = 2'b11; s_target = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        s_valid = 1'b0;
        checks++;
        if (total !== 8'd255 || correct !== 8'd255 || all_ok !== 1'b1) begin
            errors++;
            $display("FAIL sat_counters total=%0d correct=%0d all_ok=%0b required 255 255 1",
                     total, correct, all_ok);
        end
        load(8'd0, 8'd0);
        checks++;
        if (total !== 8'd0 || correct !== 8'd0 || all_ok !== 1'b0) begin
            errors++;
            $display("FAIL sat_reload total=%0d correct=%0d all_ok=%0b required 0 0 0",
                     total, correct, all_ok);
        end
    endtask

    task automatic test_reset_mid;
        p_ready = 1'b1;
        load(8'd1, 8'd1);
        p_ready = 1'b0;
        send(2'b01, 1'b1);
        checks++;
        if (p_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid got=%0b required 1", p_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (p_valid !== 1'b0 || loaded !== 1'b0 || total !== 8'd0 || correct !== 8'd0 ||
            w_ready !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid=%0b loaded=%0b total=%0d correct=%0d w_rdy=%0b s_rdy=%0b required 0 0 0 0 1 0",
                     p_valid, loaded, total, correct, w_ready, s_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        p_ready = 1'b1;
        s_valid = 1'b1; s_x = 2'b01; s_target = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        checks++;
        if (p_valid !== 1'b0 || total !== 8'd0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_refuse valid=%0b total=%0d s_rdy=%0b required 0 0 0",
                     p_valid, total, s_ready);
        end
        load(8'd1, 8'd0);
        send(2'b01, 1'b1);
        checks++;
        if (p_y !== 1'b1 || p_err !== 2'b00 || total !== 8'd1 || correct !== 8'd1) begin
            errors++;
            $display("FAIL mid_recover y=%0b err=%b total=%0d correct=%0d required 1 00 1 1",
                     p_y, p_err, total, correct);
        end
    endtask

    initial begin
        test_reset;
        test_or_gate;
        test_zero_weights;
        test_extremes;
        test_back_to_back;
        test_saturation;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1);
    end

endmodule
